// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module  : fir_ctrl_pkg
// Purpose : State encoding and default widths shared by the FIR frame controller.
// Rev     : 1.0  initial release
//==============================================================================
package fir_ctrl_pkg;

   localparam int unsigned c_DEF_ADDR_W = 8;
   localparam int unsigned c_DEF_COEF_W = 14;
   localparam int unsigned c_DEF_N_TAPS = 6;

   typedef logic [2:0] fir_state_t;

   localparam fir_state_t c_ST_IDLE  = 3'd0;
   localparam fir_state_t c_ST_CLEAR = 3'd1;
   localparam fir_state_t c_ST_RUN   = 3'd2;
   localparam fir_state_t c_ST_DRAIN = 3'd3;
   localparam fir_state_t c_ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fir_vld_delay.sv
`default_nettype none
//==============================================================================
// Module  : fir_vld_delay
// Purpose : Reset-cleared 1-bit valid delay line with an in-flight flag.
// Rev     : 1.0  initial release
//==============================================================================
module fir_vld_delay
   import fir_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_vld,
   output logic o_vld,
   output logic o_pend
);

   // o_pend flags valids still queued behind the output stage
   generate
      if (DEPTH == 0) begin : g_wire
         logic w_unused;
         assign w_unused = clk ^ rst;
         assign o_vld    = i_vld;
         assign o_pend   = 1'b0;
      end else if (DEPTH == 1) begin : g_one
         logic r_pipe;
         always_ff @(posedge clk) begin
            if (rst) r_pipe <= 1'b0;
            else     r_pipe <= i_vld;
         end
         assign o_vld  = r_pipe;
         assign o_pend = 1'b0;
      end else begin : g_shift
         logic [DEPTH-1:0] r_pipe;
         always_ff @(posedge clk) begin
            if (rst) r_pipe <= '0;
            else     r_pipe <= {r_pipe[DEPTH-2:0], i_vld};
         end
         assign o_vld  = r_pipe[DEPTH-1];
         assign o_pend = |r_pipe[DEPTH-2:0];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/fir_frame_ctrl.sv
`default_nettype none
//==============================================================================
// Module  : fir_frame_ctrl
// Purpose : Frame sequencer for the 6-tap FIR: coef latch, read/write addressing.
// Rev     : 1.0  initial release
//==============================================================================
module fir_frame_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W     = c_DEF_ADDR_W,
   parameter int unsigned N_SAMPLES  = 256,
   parameter int unsigned N_TAPS     = c_DEF_N_TAPS,
   parameter int unsigned COEF_W     = c_DEF_COEF_W,
   parameter int unsigned MEM_RD_LAT = 1,
   parameter int unsigned FILT_LAT   = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       hold,
   input  logic [N_TAPS*COEF_W-1:0]   coef_in,
   output logic [N_TAPS*COEF_W-1:0]   coef_out,
   output logic                       filt_clr,
   output logic                       in_rd_en,
   output logic [ADDR_W-1:0]          in_addr,
   output logic                       filt_vld,
   output logic                       out_wr_en,
   output logic [ADDR_W-1:0]          out_addr,
   output logic                       busy,
   output logic                       done
);

   localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(N_SAMPLES - 1);

   fir_state_t                 r_state;
   fir_state_t                 w_state_nxt;
   logic [ADDR_W-1:0]          r_rd_cnt;
   logic [ADDR_W-1:0]          r_wr_cnt;
   logic [N_TAPS*COEF_W-1:0]   r_coef;
   logic                       w_rd_en;
   logic                       w_filt_vld;
   logic                       w_wr_en;
   logic                       w_mem_pend;
   logic                       w_filt_pend;
   logic                       w_last_rd;
   logic                       w_pipe_empty;

   assign w_rd_en   = (r_state == c_ST_RUN) && !hold;
   assign w_last_rd = w_rd_en && (r_rd_cnt == c_LAST);

   // True on the cycle the final write leaves the pipe: nothing queued behind it
   assign w_pipe_empty = !w_mem_pend && !w_filt_pend && !((FILT_LAT != 0) && w_filt_vld);

   fir_vld_delay #(.DEPTH(MEM_RD_LAT)) u_rd_pipe (
      .clk    (clk),
      .rst    (reset),
      .i_vld  (w_rd_en),
      .o_vld  (w_filt_vld),
      .o_pend (w_mem_pend)
   );

   fir_vld_delay #(.DEPTH(FILT_LAT)) u_filt_pipe (
      .clk    (clk),
      .rst    (reset),
      .i_vld  (w_filt_vld),
      .o_vld  (w_wr_en),
      .o_pend (w_filt_pend)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (start) w_state_nxt = c_ST_CLEAR;
         c_ST_CLEAR: w_state_nxt = c_ST_RUN;
         c_ST_RUN:   if (w_last_rd) w_state_nxt = c_ST_DRAIN;
         c_ST_DRAIN: if (w_pipe_empty) w_state_nxt = c_ST_DONE;
         c_ST_DONE:  w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= c_ST_IDLE;
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
         r_coef   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == c_ST_CLEAR) begin
            r_coef   <= coef_in;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
         end else begin
            if (w_rd_en) r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
            if (w_wr_en) r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
         end
      end
   end

   assign coef_out  = r_coef;
   assign filt_clr  = (r_state == c_ST_CLEAR);
   assign in_rd_en  = w_rd_en;
   assign in_addr   = r_rd_cnt;
   assign filt_vld  = w_filt_vld;
   assign out_wr_en = w_wr_en;
   assign out_addr  = r_wr_cnt;
   assign busy      = (r_state != c_ST_IDLE);
   assign done      = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
